// File: rtl/mem_stage_ctrl_if.sv
// Bus between the EX/MEM pipeline register and the MEM-stage data memory responder.
// Signal suffixes are from the responder's point of view; misalign_o exists only with MEM_STAGE_MISALIGN_CHK_EN.
interface mem_stage_ctrl_if;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    logic        misalign_o;

    modport master (
        output mem_read_i, mem_write_i, addr_i, wdata_i,
        input  rdata_o, stall_o, misalign_o
    );

    modport slave (
        input  mem_read_i, mem_write_i, addr_i, wdata_i,
        output rdata_o, stall_o, misalign_o
    );
`else
    modport master (
        output mem_read_i, mem_write_i, addr_i, wdata_i,
        input  rdata_o, stall_o
    );

    modport slave (
        input  mem_read_i, mem_write_i, addr_i, wdata_i,
        output rdata_o, stall_o
    );
`endif
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data memory responder: fixed-latency word array access that stalls the pipeline until done.
// Optional MEM_STAGE_MISALIGN_CHK_EN suppresses accesses with addr[1:0]!=0 and flags them on misalign_o.
module mem_stage_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    mem_stage_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic               isWrite_q, isWrite_d;
    logic [IDX_W-1:0]   wordIdx_q, wordIdx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               stallRaw;
    logic               request;
    logic               reqMisaligned;
    logic               commit;
    logic               accWrite;
    logic               accMisaligned;
    logic [IDX_W-1:0]   accIdx;
    logic [31:0]        accWdata;
    logic               unusedAddr;

    logic [31:0]        mem [DEPTH];

    assign request = bus.mem_read_i | bus.mem_write_i;

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    logic misaligned_q, misaligned_d;
    logic misalign_q, misalign_d;

    assign reqMisaligned  = |bus.addr_i[1:0];
    assign accMisaligned  = (state_q == IDLE) ? reqMisaligned : misaligned_q;
    assign misalign_d     = commit & accMisaligned;
    assign bus.misalign_o = misalign_q;
    assign unusedAddr     = ^bus.addr_i[31:IDX_W+2];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            misaligned_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
            misalign_q   <= misalign_d;
        end
    end
`else
    assign reqMisaligned = 1'b0;
    assign accMisaligned = 1'b0;
    assign unusedAddr    = ^{bus.addr_i[31:IDX_W+2], bus.addr_i[1:0]};
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        isWrite_d = isWrite_q;
        wordIdx_d = wordIdx_q;
        wdata_d   = wdata_q;
        stallRaw  = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        misaligned_d = misaligned_q;
`endif
        case (state_q)
            IDLE: begin
                if (request) begin
                    stallRaw  = 1'b1;
                    count_d   = 4'(LATENCY - 1);
                    isWrite_d = bus.mem_write_i;
                    wordIdx_d = bus.addr_i[IDX_W+1:2];
                    wdata_d   = bus.wdata_i;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
                    misaligned_d = reqMisaligned;
`endif
                    state_d   = (LATENCY > 1) ? BUSY : DONE;
                end
            end
            BUSY: begin
                stallRaw = 1'b1;
                count_d  = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With LATENCY=1 DONE is entered straight from IDLE, so the commit must use the live inputs.
    assign accWrite = (state_q == IDLE) ? bus.mem_write_i : isWrite_q;
    assign accIdx   = (state_q == IDLE) ? bus.addr_i[IDX_W+1:2] : wordIdx_q;
    assign accWdata = (state_q == IDLE) ? bus.wdata_i : wdata_q;
    assign commit   = rst_n_i && (state_d == DONE) && (state_q != DONE);

    always_comb begin
        rdata_d = rdata_q;
        if (commit && !accWrite) begin
            rdata_d = accMisaligned ? 32'd0 : mem[accIdx];
        end
    end

    assign bus.stall_o = rst_n_i & stallRaw;
    assign bus.rdata_o = rdata_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            isWrite_q <= 1'b0;
            wordIdx_q <= '0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            isWrite_q <= isWrite_d;
            wordIdx_q <= wordIdx_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // The array keeps its contents through reset.
    always_ff @(posedge clk_i) begin
        if (commit && accWrite && !accMisaligned) begin
            mem[accIdx] <= accWdata;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: randomized and directed accesses against a word-array model.
// Exercises misalign_o as well when MEM_STAGE_MISALIGN_CHK_EN is defined.
module tb_mem_stage_ctrl;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] modelMem [DEPTH];
    logic [31:0] modelRdata = 32'd0;

    mem_stage_ctrl_if bus();

    mem_stage_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleInputs();
        bus.mem_read_i  = 1'b0;
        bus.mem_write_i = 1'b0;
        bus.addr_i      = 32'd0;
        bus.wdata_i     = 32'd0;
    endtask

    // One full access starting just after a rising edge; returns just after the edge leaving DONE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit garbage, input string name);
        int   stalls;
        bit   done;
        int   idx;
        bit   expMis;
        idx    = int'((addr >> 2) % DEPTH);
        expMis = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        expMis = (addr % 4) != 0;
`endif
        if (wr) begin
            if (!expMis) modelMem[idx] = wdata;
        end else if (rd) begin
            modelRdata = expMis ? 32'd0 : modelMem[idx];
        end
        bus.mem_read_i  = rd;
        bus.mem_write_i = wr;
        bus.addr_i      = addr;
        bus.wdata_i     = wdata;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < LATENCY + 4 && !done; c++) begin
            @(negedge clk);
            if (bus.stall_o === 1'b1) begin
                stalls++;
                @(posedge clk); #1;
                if (garbage) begin
                    bus.mem_read_i  = 1'($urandom);
                    bus.mem_write_i = 1'($urandom);
                    bus.addr_i      = $urandom;
                    bus.wdata_i     = $urandom;
                end
            end else begin
                done = 1'b1;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: stall still high after %0d cycles, required %0d", name, stalls, LATENCY);
        end else if (stalls != LATENCY) begin
            miscompares++;
            $display("[TB] FAIL %s stall cycles: got %0d, required %0d", name, stalls, LATENCY);
        end
        vectors++;
        if (bus.rdata_o !== modelRdata) begin
            miscompares++;
            $display("[TB] FAIL %s rdata: got %h, required %h", name, bus.rdata_o, modelRdata);
        end
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        vectors++;
        if (bus.misalign_o !== expMis) begin
            miscompares++;
            $display("[TB] FAIL %s misalign: got %b, required %b", name, bus.misalign_o, expMis);
        end
`endif
        @(posedge clk); #1;
        idleInputs();
    endtask

    task automatic test_reset();
        idleInputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelRdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.stall_o !== 1'b0 || bus.rdata_o !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset idle: stall=%b rdata=%h, required stall=0 rdata=0", bus.stall_o, bus.rdata_o);
            end
`ifdef MEM_STAGE_MISALIGN_CHK_EN
            vectors++;
            if (bus.misalign_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset misalign: got %b, required 0", bus.misalign_o);
            end
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, "fill");
        end
    endtask

    task automatic test_store_load();
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "store_0x10");
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "load_0x10");
        vectors++;
        if (bus.rdata_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL load_0x10 direct: got %h, required deadbeef", bus.rdata_o);
        end
    endtask

    task automatic test_wrap();
        access(1'b0, 1'b1, 32'h400, 32'h1234, 1'b0, "store_0x400");
        access(1'b1, 1'b0, 32'h000, 32'h0, 1'b0, "load_wrap");
        vectors++;
        if (bus.rdata_o !== 32'h1234) begin
            miscompares++;
            $display("[TB] FAIL load_wrap direct: got %h, required 00001234", bus.rdata_o);
        end
    endtask

    task automatic test_both_high();
        access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, "prep_store");
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "prep_load");
        access(1'b1, 1'b1, 32'h20, 32'h55, 1'b0, "both_high");
        vectors++;
        if (bus.rdata_o !== 32'hCAFEF00D) begin
            miscompares++;
            $display("[TB] FAIL both_high keep: got %h, required cafef00d", bus.rdata_o);
        end
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "load_0x20");
        vectors++;
        if (bus.rdata_o !== 32'h55) begin
            miscompares++;
            $display("[TB] FAIL load_0x20 direct: got %h, required 00000055", bus.rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            access(1'b0, 1'b1, a, d, 1'b1, "b2b_store");
            access(1'b1, 1'b0, a, 32'h0, 1'b1, "b2b_load");
            vectors++;
            if (bus.rdata_o !== d) begin
                miscompares++;
                $display("[TB] FAIL b2b direct: got %h, required %h", bus.rdata_o, d);
            end
        end
    endtask

    task automatic test_random();
        int op;
        int gap;
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 2));
            access(op != 1, op != 0, $urandom, $urandom, 1'($urandom), "random");
            if ($urandom_range(0, 3) == 0) begin
                gap = int'($urandom_range(1, 3));
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    vectors++;
                    if (bus.stall_o !== 1'b0 || bus.rdata_o !== modelRdata) begin
                        miscompares++;
                        $display("[TB] FAIL idle gap: stall=%b rdata=%h, required stall=0 rdata=%h",
                                 bus.stall_o, bus.rdata_o, modelRdata);
                    end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        access(1'b0, 1'b1, 32'h30, 32'h1111, 1'b0, "pre_store_0x30");
        access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, "pre_load_0x30");
        bus.mem_write_i = 1'b1;
        bus.addr_i      = 32'h30;
        bus.wdata_i     = 32'hAAAA;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        modelRdata = 32'd0;
        vectors++;
        if (bus.stall_o !== 1'b0 || bus.rdata_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: stall=%b rdata=%h, required stall=0 rdata=0", bus.stall_o, bus.rdata_o);
        end
        idleInputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, "post_reset_load");
        vectors++;
        if (bus.rdata_o !== 32'h1111) begin
            miscompares++;
            $display("[TB] FAIL post_reset_load direct: got %h, required 00001111", bus.rdata_o);
        end
    endtask

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    task automatic test_misalign();
        access(1'b0, 1'b1, 32'h10, 32'h600DD00D, 1'b0, "mis_prep");
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "mis_prep_load");
        access(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, "mis_load");
        @(negedge clk);
        vectors++;
        if (bus.misalign_o !== 1'b0 || bus.rdata_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL mis_after: misalign=%b rdata=%h, required 0 and 0", bus.misalign_o, bus.rdata_o);
        end
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'h11, 32'hBAD0BAD0, 1'b0, "mis_store");
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "mis_check");
        vectors++;
        if (bus.rdata_o !== 32'h600DD00D) begin
            miscompares++;
            $display("[TB] FAIL mis_check direct: got %h, required 600dd00d", bus.rdata_o);
        end
    endtask
`endif

    initial begin
        idleInputs();
        test_reset();
        test_fill();
        test_store_load();
        test_wrap();
        test_both_high();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM-stage data-memory responder for the 5-stage pipeline. It consumes the MemRead/MemWrite strobes, ALU address and store data held in the EX/MEM register, and services them against an internal word-addressed data array with a fixed multi-cycle access latency. It drives the stall line back into the EX/MEM (and upstream) registers so they hold their contents until the access completes. It returns load data toward MEM/WB.

Parameters:
DEPTH, 256, number of 32-bit words in the data array (power of two)
LATENCY, 3, stall cycles per access (1..15)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
mem_read_i  input  1  load request from EX/MEM (MemRead)
mem_write_i  input  1  store request from EX/MEM (MemWrite)
addr_i  input  32  byte address from EX/MEM ALU result
wdata_i  input  32  store data from EX/MEM
rdata_o  output  32  load data toward MEM/WB, registered
stall_o  output  1  hold request to the EX/MEM register and upstream stages

Behaviour:
- Clock clk_i, single domain; reset rst_n_i asynchronous, active-low.
- Word index is addr_i[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words. addr_i[1:0] is ignored unless the optional feature is enabled.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stall_o=0.
- IDLE, mem_read_i or mem_write_i high (cycle T):
  - stall_o=1, combinationally in cycle T.
  - Capture op, index and wdata into internal registers.
  - Load the counter with LATENCY-1.
  - Next state is BUSY if LATENCY>1, otherwise DONE.
- BUSY: stall_o=1. The counter decrements each cycle. When the counter equals 1, go to DONE.
- Edge entering DONE:
  - Store: array[index] <= captured wdata.
  - Load: rdata_o <= array[index].
- DONE (cycle T+LATENCY): stall_o=0, so the pipeline advances on this edge. The next state is always IDLE. The request still present on the inputs during DONE is the completed one and must not start a new access.
- Total stall per access is exactly LATENCY cycles. The next request can be accepted at the earliest in cycle T+LATENCY+1.
- Inputs are sampled only in IDLE. Input changes during BUSY/DONE are ignored.
- mem_read_i and mem_write_i both high: treated as a store. rdata_o is unchanged.
- rdata_o holds its last load value across stores and idle cycles.
- Reset values: state=IDLE, stall_o=0, rdata_o=0, counter=0.
- Reset asserted mid-access:
  - The FSM aborts to IDLE and no write is committed.
  - The array contents are not cleared, so the array needs no reset logic.

Optional Feature:
Macro MEM_STAGE_MISALIGN_CHK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A request in IDLE with addr_i[1:0]!=0 still stalls the full LATENCY cycles, but the access is suppressed: no array write, and rdata_o <= 0 on a load.
  - misalign_o is high for exactly the DONE cycle of that access.
- Not defined: the port is absent and addr_i[1:0] is ignored.

Test Plan:
- Reset, then idle with no requests: stall_o=0 and rdata_o=0 at all times.
- Store wdata=0xDEADBEEF to addr 0x10 in cycle T (LATENCY=3): stall_o=1 in T..T+2 and 0 in T+3; then a load from 0x10 gives rdata_o=0xDEADBEEF in its DONE cycle, with 3 stall cycles.
- Wrap: store 0x1234 to addr 0x400 (DEPTH=256), then load from addr 0x000 -> rdata_o=0x1234.
- Read and write both high, addr 0x20, wdata 0x55: the access is a store, rdata_o keeps its prior value, and a later load of 0x20 returns 0x55.
- Assert rst_n_i low in the BUSY cycle of a store of 0xAAAA to 0x30 whose location held 0x1111: stall_o drops to 0 immediately, rdata_o=0, and a load of 0x30 after reset returns 0x1111.
- With MEM_STAGE_MISALIGN_CHK_EN defined, load from 0x13: 3 stall cycles, then misalign_o=1 for one cycle and rdata_o=0; the array is unchanged.
